// File: rtl/dmem_arbiter.sv
// Two-port arbiter serialising CPU and loader accesses onto one synchronous data RAM.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; the default build uses fixed CPU priority.
module dmem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

`ifdef DMEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    localparam logic GRANT_CPU = 1'b1;
    localparam logic GRANT_LDR = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        CAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_r;
    logic   owner_r;
    logic   owner_we_r;
    logic   last_grant_r;
    logic   grant_cpu_s;

    // Winner selection for the IDLE cycle; ties go to CPU unless round-robin is built in.
    always_comb begin
        grant_cpu_s = GRANT_LDR;
        if (cpu_req && ldr_req) begin
            grant_cpu_s = RR_EN ? (last_grant_r == GRANT_LDR) : GRANT_CPU;
        end else if (cpu_req) begin
            grant_cpu_s = GRANT_CPU;
        end else begin
            grant_cpu_s = GRANT_LDR;
        end
    end

    // Combinational stall so the CPU freezes in the same cycle it raises its request.
    assign cpu_stall = cpu_req & ~cpu_ack;

    // Access sequencer: every memory-facing and handshake output is a register here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            owner_r      <= GRANT_LDR;
            owner_we_r   <= 1'b0;
            last_grant_r <= GRANT_LDR;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_ack      <= 1'b0;
            ldr_ack      <= 1'b0;
            cpu_rdata    <= '0;
            ldr_rdata    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cpu_req || ldr_req) begin
                        owner_r    <= grant_cpu_s;
                        owner_we_r <= grant_cpu_s ? cpu_we : ldr_we;
                        mem_en     <= 1'b1;
                        mem_we     <= grant_cpu_s ? cpu_we : ldr_we;
                        mem_addr   <= grant_cpu_s ? cpu_addr : ldr_addr;
                        mem_wdata  <= grant_cpu_s ? cpu_wdata : ldr_wdata;
                        state_r    <= ACC;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                ACC: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    state_r   <= CAP;
                end
                CAP: begin
                    // Read data from the RAM is valid now, one cycle after the enable.
                    if (owner_r == GRANT_CPU) begin
                        cpu_ack <= 1'b1;
                        if (!owner_we_r) begin
                            cpu_rdata <= mem_rdata;
                        end else begin
                            cpu_rdata <= cpu_rdata;
                        end
                    end else begin
                        ldr_ack <= 1'b1;
                        if (!owner_we_r) begin
                            ldr_rdata <= mem_rdata;
                        end else begin
                            ldr_rdata <= ldr_rdata;
                        end
                    end
                    state_r <= DONE;
                end
                DONE: begin
                    cpu_ack      <= 1'b0;
                    ldr_ack      <= 1'b0;
                    last_grant_r <= owner_r;
                    state_r      <= IDLE;
                end
                default: begin
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    cpu_ack <= 1'b0;
                    ldr_ack <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed accesses push expected (owner, rdata)
// into a queue; a monitor pops and compares on every ack pulse.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, ldr_req, ldr_we;
    logic [15:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
    logic [15:0] cpu_rdata, ldr_rdata;
    logic        cpu_ack, cpu_stall, ldr_ack;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_cpu;
        logic [15:0] rdata;
    } exp_t;
    exp_t sb[$];

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM model with fixed preloaded contents.
    logic [15:0]  ram [0:255];
    logic [255:0] wr_mask = '0;

    function automatic logic [15:0] ram_init(input logic [7:0] a);
        case (a)
            8'h10:   return 16'hBEEF;
            8'h40:   return 16'hAAAA;
            8'h50:   return 16'h5555;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr[7:0]]     <= mem_wdata;
                wr_mask[mem_addr[7:0]] <= 1'b1;
            end else begin
                mem_rdata <= wr_mask[mem_addr[7:0]] ? ram[mem_addr[7:0]] : ram_init(mem_addr[7:0]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every ack pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (cpu_ack || ldr_ack)) begin
            exp_t e;
            chk("ack_exclusive", {31'd0, cpu_ack & ldr_ack}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'd0, cpu_ack, ldr_ack}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_owner", {31'd0, cpu_ack}, {31'd0, e.is_cpu});
                if (e.is_cpu) chk("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, e.rdata});
                else          chk("ldr_rdata", {16'd0, ldr_rdata}, {16'd0, e.rdata});
            end
        end
    end

    task automatic drive(input bit is_cpu, input bit we, input logic [15:0] addr,
                         input logic [15:0] wdata);
        if (is_cpu) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end else begin
            ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
        end
    endtask

    // One uncontended access started right after a rising edge; checks latency and strobes.
    task automatic do_access(input bit is_cpu, input bit we, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic [15:0] exp_rdata);
        int   lat;
        exp_t e;
        lat = -1;
        e.is_cpu = is_cpu;
        e.rdata  = exp_rdata;
        sb.push_back(e);
        drive(is_cpu, we, addr, wdata);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mem_en_timing", {31'd0, mem_en}, {31'd0, (i == 1)});
            chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, (is_cpu && i < 3)});
            if (i == 1) begin
                chk("mem_we", {31'd0, mem_we}, {31'd0, we});
                chk("mem_addr", {16'd0, mem_addr}, {16'd0, addr});
            end
            if (is_cpu ? cpu_ack : ldr_ack) begin
                lat = i;
                break;
            end
        end
        chk("ack_latency", lat, 32'd3);
        @(posedge clk); #1;
        if (is_cpu) cpu_req = 1'b0; else ldr_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   ack_t[$];
        exp_t e;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 16'h0000; ldr_wdata = 16'h0000;

        // Reset state
        @(negedge clk);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_acks", {30'd0, cpu_ack, ldr_ack}, 32'd0);
        chk("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
        chk("rst_ldr_rdata", {16'd0, ldr_rdata}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: CPU read of preloaded word
        do_access(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
        // 2: loader write then CPU read-back; loader rdata stays at reset value
        do_access(1'b0, 1'b1, 16'h0020, 16'h1234, 16'h0000);
        do_access(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234);
        chk("ldr_rdata_after_write", {16'd0, ldr_rdata}, 32'd0);
        // 6: loader read must not disturb CPU's held rdata
        do_access(1'b1, 1'b0, 16'h0040, 16'h0000, 16'hAAAA);
        do_access(1'b0, 1'b0, 16'h0050, 16'h0000, 16'h5555);
        chk("cpu_rdata_held", {16'd0, cpu_rdata}, 32'h0000AAAA);
        do_access(1'b1, 1'b1, 16'h0044, 16'h1111, 16'hAAAA);

        // 5: CPU drops req during CAP; ack still arrives, then nothing further
        e.is_cpu = 1'b1; e.rdata = 16'hBEEF;
        sb.push_back(e);
        drive(1'b1, 1'b0, 16'h0010, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("drop_mem_en", {31'd0, mem_en}, {31'd0, (i == 1)});
            chk("drop_cpu_ack", {31'd0, cpu_ack}, {31'd0, (i == 3)});
            if (i == 1) begin
                @(posedge clk); #1;
                cpu_req = 1'b0;
            end
        end

        // 4: reset during ACC of a CPU write
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 16'h0060, 16'h7777);
        @(posedge clk); #1;
        chk("acc_mem_en", {31'd0, mem_en}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_async_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        chk("rst_async_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
        chk("rst_async_ldr_rdata", {16'd0, ldr_rdata}, 32'd0);
        cpu_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("aborted_write", {31'd0, wr_mask[8'h60]}, 32'd0);

        // 3: both requesting at reset release, held high
        drive(1'b1, 1'b0, 16'h0010, 16'h0000);
        drive(1'b0, 1'b0, 16'h0050, 16'h0000);
        for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
            e.is_cpu = (k % 2 == 0);
`else
            e.is_cpu = 1'b1;
`endif
            e.rdata = e.is_cpu ? 16'hBEEF : 16'h5555;
            sb.push_back(e);
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (cpu_ack || ldr_ack) ack_t.push_back(i);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        chk("tie_ack_count", ack_t.size(), 32'd4);
        for (int k = 0; k < ack_t.size() && k < 4; k++) begin
            chk("tie_ack_cycle", ack_t[k], 3 + 4 * k);
        end
        repeat (8) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
